// File: rtl/tap_counter_pkg.sv
// tap_counter_pkg: shared state type and USB bit-counter defaults for tap_flex_counter
package tap_counter_pkg;
    typedef enum logic {RUN, HOLD} state_e;
    localparam int BIT_CNT_W    = 5;
    localparam int BIT_ROLLOVER = 25;
    localparam int TAP_BYTE0    = 7;
    localparam int TAP_BYTE1    = 15;
    localparam int TAP_CRC      = 24;
endpackage

// File: rtl/tap_cmp.sv
// tap_cmp: registered equality compare of next count against a run-time value
module tap_cmp #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o
);
    logic eq_q;
    // flag lands in the same cycle the compared count appears on count_out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) eq_q <= 1'b0;
        else     eq_q <= (a_i == b_i);
    end
    assign eq_o = eq_q;
endmodule

// File: rtl/tap_flex_counter.sv
// tap_flex_counter: enabled bit counter with run-time rollover, tap flags, wrap count and one-shot hold
module tap_flex_counter
    import tap_counter_pkg::*;
#(
    parameter int WIDTH    = BIT_CNT_W,
    parameter int NUM_TAPS = 3,
    parameter int WRAP_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      count_enable,
    input  logic                      clear,
    input  logic                      one_shot,
    input  logic [WIDTH-1:0]          rollover_val,
    input  logic [NUM_TAPS*WIDTH-1:0] tap_vals,
    output logic [WIDTH-1:0]          count_out,
    output logic                      roll_over,
    output logic [NUM_TAPS-1:0]       tap_flag,
    output logic [WRAP_W-1:0]         wrap_count,
    output logic                      done
);
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              at_term;
    assign at_term = (count_q == rollover_val);
    // state, count and wrap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            count_q <= '0;
            wrap_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end
    // clear wins; HOLD freezes; RUN advances on enable, terminating at rollover_val
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = wrap_q;
        if (clear) begin
            state_d = RUN;
            count_d = '0;
            wrap_d  = '0;
        end else if (state_q == RUN && count_enable) begin
            if (!at_term) begin
                count_d = count_q + 1'b1;
            end else if (one_shot) begin
                state_d = HOLD;
            end else begin
                count_d = '0;
                wrap_d  = (wrap_q == {WRAP_W{1'b1}}) ? wrap_q : wrap_q + 1'b1;
            end
        end
    end
    tap_cmp #(.WIDTH(WIDTH)) u_roll (
        .clk (clk),
        .rst (rst),
        .a_i (count_d),
        .b_i (rollover_val),
        .eq_o(roll_over)
    );
    genvar g;
    generate
        for (g = 0; g < NUM_TAPS; g++) begin : g_tap
            tap_cmp #(.WIDTH(WIDTH)) u_tap (
                .clk (clk),
                .rst (rst),
                .a_i (count_d),
                .b_i (tap_vals[g*WIDTH +: WIDTH]),
                .eq_o(tap_flag[g])
            );
        end
    endgenerate
    assign count_out  = count_q;
    assign wrap_count = wrap_q;
    assign done       = (state_q == HOLD);
endmodule

// File: tb/tb_tap_flex_counter.sv
// tb_tap_flex_counter: directed scenario bench for tap_flex_counter
module tb_tap_flex_counter;
    import tap_counter_pkg::*;
    logic        clk = 1'b0;
    logic        rst, count_enable, clear, one_shot;
    logic [4:0]  rollover_val;
    logic [14:0] tap_vals;
    logic [4:0]  count_out, count_out2;
    logic        roll_over, roll_over2, done, done2;
    logic [2:0]  tap_flag, tap_flag2;
    logic [3:0]  wrap_count;
    logic [1:0]  wrap_count2;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tap_flex_counter #(.WIDTH(5), .NUM_TAPS(3), .WRAP_W(4)) u_dut (
        .clk(clk), .rst(rst), .count_enable(count_enable), .clear(clear),
        .one_shot(one_shot), .rollover_val(rollover_val), .tap_vals(tap_vals),
        .count_out(count_out), .roll_over(roll_over), .tap_flag(tap_flag),
        .wrap_count(wrap_count), .done(done)
    );

    tap_flex_counter #(.WIDTH(5), .NUM_TAPS(3), .WRAP_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .count_enable(count_enable), .clear(clear),
        .one_shot(one_shot), .rollover_val(rollover_val), .tap_vals(tap_vals),
        .count_out(count_out2), .roll_over(roll_over2), .tap_flag(tap_flag2),
        .wrap_count(wrap_count2), .done(done2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; count_enable = 1'b0; clear = 1'b0; one_shot = 1'b0;
        rollover_val = 5'(BIT_ROLLOVER);
        tap_vals = {5'(TAP_CRC), 5'(TAP_BYTE1), 5'(TAP_BYTE0)};
        step();
        step();
        n_checks++;
        if (count_out !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_out); end
        n_checks++;
        if ({roll_over, tap_flag, done} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {roll_over, tap_flag, done}); end
        n_checks++;
        if (wrap_count !== 4'd0) begin n_fail++; $display("FAIL reset_wrap: got %0d want 0", wrap_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_free_run();
        logic [4:0] c;
        logic [2:0] t;
        count_enable = 1'b1;
        for (int i = 1; i <= 26; i++) begin
            step();
            c = 5'(i % 26);
            t = {c == 5'd24, c == 5'd15, c == 5'd7};
            n_checks++;
            if (count_out !== c) begin n_fail++; $display("FAIL free_count[%0d]: got %0d want %0d", i, count_out, c); end
            n_checks++;
            if (tap_flag !== t) begin n_fail++; $display("FAIL free_tap[%0d]: got %b want %b", i, tap_flag, t); end
            n_checks++;
            if (roll_over !== (c == 5'd25)) begin n_fail++; $display("FAIL free_roll[%0d]: got %b want %b", i, roll_over, c == 5'd25); end
            n_checks++;
            if (wrap_count !== ((i == 26) ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL free_wrap[%0d]: got %0d", i, wrap_count); end
        end
        count_enable = 1'b0;
        do_clear();
    endtask

    task automatic test_enable_toggle();
        int exp_c[12] = '{1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2};
        rollover_val = 5'd3;
        for (int i = 0; i < 12; i++) begin
            count_enable = (i % 2 == 0);
            step();
            n_checks++;
            if (count_out !== 5'(exp_c[i])) begin n_fail++; $display("FAIL toggle_count[%0d]: got %0d want %0d", i, count_out, exp_c[i]); end
            n_checks++;
            if (roll_over !== (exp_c[i] == 3)) begin n_fail++; $display("FAIL toggle_roll[%0d]: got %b want %b", i, roll_over, exp_c[i] == 3); end
        end
        n_checks++;
        if (wrap_count !== 4'd1) begin n_fail++; $display("FAIL toggle_wrap: got %0d want 1", wrap_count); end
        count_enable = 1'b0;
        do_clear();
    endtask

    task automatic test_one_shot();
        one_shot = 1'b1; rollover_val = 5'd10; count_enable = 1'b1;
        repeat (10) step();
        n_checks++;
        if ({count_out, done, roll_over} !== {5'd10, 1'b0, 1'b1}) begin n_fail++; $display("FAIL oneshot_reach: got cnt=%0d done=%b roll=%b want 10 0 1", count_out, done, roll_over); end
        step();
        n_checks++;
        if ({count_out, done} !== {5'd10, 1'b1}) begin n_fail++; $display("FAIL oneshot_hold_entry: got cnt=%0d done=%b want 10 1", count_out, done); end
        one_shot = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if ({count_out, done, wrap_count} !== {5'd10, 1'b1, 4'd0}) begin n_fail++; $display("FAIL oneshot_hold[%0d]: got cnt=%0d done=%b wrap=%0d", i, count_out, done, wrap_count); end
        end
        do_clear();
        n_checks++;
        if ({count_out, done} !== {5'd0, 1'b0}) begin n_fail++; $display("FAIL oneshot_clear: got cnt=%0d done=%b want 0 0", count_out, done); end
        count_enable = 1'b0;
    endtask

    task automatic test_clear_priority();
        rollover_val = 5'd0; count_enable = 1'b1;
        step();
        step();
        n_checks++;
        if ({count_out, wrap_count} !== {5'd0, 4'd2}) begin n_fail++; $display("FAIL zero_roll: got cnt=%0d wrap=%0d want 0 2", count_out, wrap_count); end
        rollover_val = 5'd25;
        repeat (12) step();
        n_checks++;
        if ({count_out, wrap_count} !== {5'd12, 4'd2}) begin n_fail++; $display("FAIL pre_clear: got cnt=%0d wrap=%0d want 12 2", count_out, wrap_count); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if ({count_out, wrap_count} !== {5'd0, 4'd0}) begin n_fail++; $display("FAIL clear_priority: got cnt=%0d wrap=%0d want 0 0", count_out, wrap_count); end
        count_enable = 1'b0;
        step();
    endtask

    task automatic test_wrap_sat();
        rollover_val = 5'd1; count_enable = 1'b1;
        repeat (12) step();
        n_checks++;
        if (wrap_count2 !== 2'd3) begin n_fail++; $display("FAIL wrap_sat_w2: got %0d want 3", wrap_count2); end
        n_checks++;
        if (wrap_count !== 4'd6) begin n_fail++; $display("FAIL wrap_w4: got %0d want 6", wrap_count); end
        count_enable = 1'b0;
        do_clear();
    endtask

    task automatic test_async_reset();
        rollover_val = 5'd20; tap_vals = {5'd24, 5'd17, 5'd7}; count_enable = 1'b1;
        repeat (17) step();
        n_checks++;
        if ({count_out, tap_flag} !== {5'd17, 3'b010}) begin n_fail++; $display("FAIL pre_rst: got cnt=%0d tap=%b want 17 010", count_out, tap_flag); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({count_out, tap_flag, roll_over, done} !== 10'd0) begin n_fail++; $display("FAIL async_rst: got cnt=%0d tap=%b roll=%b done=%b", count_out, tap_flag, roll_over, done); end
        step();
        rst = 1'b0;
        tap_vals = {5'(TAP_CRC), 5'(TAP_BYTE1), 5'(TAP_BYTE0)};
        step();
        n_checks++;
        if (count_out !== 5'd1) begin n_fail++; $display("FAIL post_rst_first: got %0d want 1", count_out); end
        count_enable = 1'b0;
        do_clear();
    endtask

    task automatic test_lower_rollover();
        rollover_val = 5'd20; count_enable = 1'b1;
        repeat (9) step();
        rollover_val = 5'd4;
        repeat (22) step();
        n_checks++;
        if ({count_out, wrap_count} !== {5'd31, 4'd0}) begin n_fail++; $display("FAIL lower_top: got cnt=%0d wrap=%0d want 31 0", count_out, wrap_count); end
        step();
        n_checks++;
        if ({count_out, wrap_count} !== {5'd0, 4'd0}) begin n_fail++; $display("FAIL lower_natural: got cnt=%0d wrap=%0d want 0 0", count_out, wrap_count); end
        repeat (4) step();
        n_checks++;
        if ({count_out, roll_over} !== {5'd4, 1'b1}) begin n_fail++; $display("FAIL lower_term: got cnt=%0d roll=%b want 4 1", count_out, roll_over); end
        step();
        n_checks++;
        if ({count_out, wrap_count} !== {5'd0, 4'd1}) begin n_fail++; $display("FAIL lower_wrap: got cnt=%0d wrap=%0d want 0 1", count_out, wrap_count); end
        count_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_enable_toggle();
        test_one_shot();
        test_clear_priority();
        test_wrap_sat();
        test_async_reset();
        test_lower_rollover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
